// File: rtl/imem_boot_loader_if.sv
// ============================================================================
// Module      : imem_boot_loader_if
// Description : Byte-stream handshake and instruction-memory write bus used
//               by the boot loader.
//               slave  modport : the boot loader (consumes bytes, writes IMEM)
//               master modport : the byte source / memory observer
// Signals     : byte_i[7:0], byte_valid_i, byte_ready_o,
//               im_we_o, im_addr_o[31:0], im_data_o[31:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_boot_loader_if;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        im_we_o;
    logic [31:0] im_addr_o;
    logic [31:0] im_data_o;

    modport slave (
        input  byte_i,
        input  byte_valid_i,
        output byte_ready_o,
        output im_we_o,
        output im_addr_o,
        output im_data_o
    );

    modport master (
        output byte_i,
        output byte_valid_i,
        input  byte_ready_o,
        input  im_we_o,
        input  im_addr_o,
        input  im_data_o
    );
endinterface

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module      : imem_boot_loader
// Description : Loads a program into instruction memory from a byte stream.
//               Stream format: length header N (words), 4*N data bytes
//               (big-endian words), then an XOR checksum of the data bytes.
//               The CPU is held in reset until a load verifies.
// Ports       : clk_i, rst_i (async, active-low)
//               bus            - byte stream in, IMEM write bus out
//               start_i        - restart pulse, honoured in DONE/ERR only
//               cpu_rst_o      - active-low CPU reset
//               done_o, err_o  - load status
//               words_loaded_o - words written in the current load
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_loader #(
    parameter int unsigned MAX_WORDS = 32,
    parameter int unsigned CNT_W     = 6
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    imem_boot_loader_if.slave     bus,
    input  wire logic             start_i,
    output logic                  cpu_rst_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      words_loaded_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t             r_state;
    logic [1:0]         r_byte_idx;
    logic [23:0]        r_shift;      // first three bytes of the word in flight
    logic [7:0]         r_csum;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_words;
    logic               r_im_we;
    logic [31:0]        r_im_addr;
    logic [31:0]        r_im_data;
    logic               r_cpu_rst;
    logic               r_done;
    logic               r_err;

    logic               w_ready;
    logic               w_accept;
    logic               w_hdr_bad;
    logic [CNT_W-1:0]   w_words_inc;

    // Ready is a pure decode of state so the source sees backpressure
    // the same cycle the loader enters DONE or ERR.
    assign w_ready     = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_CHECK);
    assign w_accept    = bus.byte_valid_i && w_ready;
    assign w_hdr_bad   = (bus.byte_i == 8'd0) || (32'(bus.byte_i) > MAX_WORDS);
    assign w_words_inc = r_words + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_byte_idx <= 2'd0;
            r_shift    <= 24'd0;
            r_csum     <= 8'd0;
            r_len      <= '0;
            r_words    <= '0;
            r_im_we    <= 1'b0;
            r_im_addr  <= 32'd0;
            r_im_data  <= 32'd0;
            r_cpu_rst  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_im_we <= 1'b0;   // write strobe is a single-cycle pulse
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_hdr_bad) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_len      <= CNT_W'(bus.byte_i);
                            r_csum     <= 8'd0;
                            r_byte_idx <= 2'd0;
                            r_words    <= '0;
                            r_state    <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_csum  <= r_csum ^ bus.byte_i;
                        r_shift <= {r_shift[15:0], bus.byte_i};
                        if (r_byte_idx == 2'd3) begin
                            r_im_data  <= {r_shift, bus.byte_i};
                            r_im_addr  <= 32'({r_words, 2'b00});
                            r_im_we    <= 1'b1;
                            r_words    <= w_words_inc;
                            r_byte_idx <= 2'd0;
                            if (w_words_inc == r_len) begin
                                r_state <= S_CHECK;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        if (bus.byte_i == r_csum) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (start_i) begin
                        r_state   <= S_IDLE;
                        r_done    <= 1'b0;
                        r_err     <= 1'b0;
                        r_cpu_rst <= 1'b0;
                        r_words   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.byte_ready_o = w_ready;
    assign bus.im_we_o      = r_im_we;
    assign bus.im_addr_o    = r_im_addr;
    assign bus.im_data_o    = r_im_data;
    assign cpu_rst_o        = r_cpu_rst;
    assign done_o           = r_done;
    assign err_o            = r_err;
    assign words_loaded_o   = r_words;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Directed self-checking bench for imem_boot_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;

    localparam int CNT_W = 6;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             cpu_rst;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] words;

    int checks;
    int errors;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_boot_loader_if u_if();

    imem_boot_loader #(.MAX_WORDS(32), .CNT_W(CNT_W)) u_dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .bus            (u_if),
        .start_i        (start),
        .cpu_rst_o      (cpu_rst),
        .done_o         (done),
        .err_o          (err),
        .words_loaded_o (words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (u_if.im_we_o === 1'b1) begin
            wr_addr.push_back(u_if.im_addr_o);
            wr_data.push_back(u_if.im_data_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        u_if.byte_i       = b;
        u_if.byte_valid_i = 1'b1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        u_if.byte_valid_i = 1'b0;
        u_if.byte_i       = 8'h00;
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        u_if.byte_valid_i = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        u_if.byte_i = 8'h00;
        u_if.byte_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({cpu_rst, done, err, u_if.im_we_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000", {cpu_rst, done, err, u_if.im_we_o});
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (u_if.byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", u_if.byte_ready_o);
        end
        checks++;
        if (u_if.im_addr_o !== 32'd0 || u_if.im_data_o !== 32'd0 || words !== 6'd0) begin
            errors++;
            $display("FAIL reset_bus: got addr %h data %h words %0d, required 0 0 0",
                     u_if.im_addr_o, u_if.im_data_o, words);
        end
        checks++;
        if ({cpu_rst, done, err, u_if.im_we_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags_released: got %b, required 0000", {cpu_rst, done, err, u_if.im_we_o});
        end
    endtask

    task automatic test_good_load();
        logic [7:0] s [10] = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h03, 8'h05};
        clear_log();
        foreach (s[i]) send_byte(s[i]);
        idle_cycle();
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL good_status: got done %b cpu_rst %b err %b, required 1 1 0", done, cpu_rst, err);
        end
        checks++;
        if (u_if.byte_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL good_ready: got %b, required 0", u_if.byte_ready_o);
        end
        checks++;
        if (words !== 6'd2) begin
            errors++;
            $display("FAIL good_words: got %0d, required 2", words);
        end
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL good_write_count: got %0d, required 2", wr_addr.size());
        end else if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h20010005 ||
                     wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h20020003) begin
            errors++;
            $display("FAIL good_writes: got %h/%h %h/%h, required 00000000/20010005 00000004/20020003",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
        // start from DONE returns to IDLE and clears status
        pulse_start();
        checks++;
        if ({done, cpu_rst, err} !== 3'b000 || words !== 6'd0 || u_if.byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL good_restart: got done %b cpu_rst %b err %b words %0d ready %b, required 0 0 0 0 1",
                     done, cpu_rst, err, words, u_if.byte_ready_o);
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] s [10] = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h03, 8'h06};
        clear_log();
        foreach (s[i]) send_byte(s[i]);
        idle_cycle();
        checks++;
        if (err !== 1'b1 || cpu_rst !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL badsum_status: got err %b cpu_rst %b done %b, required 1 0 0", err, cpu_rst, done);
        end
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL badsum_write_count: got %0d, required 2", wr_addr.size());
        end
        // start is ignored while loading would be wrong here; in ERR it restarts
        pulse_start();
        checks++;
        if (err !== 1'b0 || u_if.byte_ready_o !== 1'b1 || cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL badsum_restart: got err %b ready %b cpu_rst %b, required 0 1 0",
                     err, u_if.byte_ready_o, cpu_rst);
        end
    endtask

    task automatic test_bad_header();
        logic [7:0] hdr [2] = '{8'd0, 8'd33};
        foreach (hdr[i]) begin
            clear_log();
            send_byte(hdr[i]);
            idle_cycle();
            checks++;
            if (err !== 1'b1 || u_if.byte_ready_o !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL badhdr_%0d: got err %b ready %b done %b, required 1 0 0",
                         hdr[i], err, u_if.byte_ready_o, done);
            end
            idle_cycle();
            checks++;
            if (wr_addr.size() != 0) begin
                errors++;
                $display("FAIL badhdr_%0d_writes: got %0d, required 0", hdr[i], wr_addr.size());
            end
            pulse_start();
        end
    endtask

    task automatic test_gap();
        logic [7:0] a [3] = '{8'h02, 8'h20, 8'h01};
        logic [7:0] b [7] = '{8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h03, 8'h05};
        clear_log();
        foreach (a[i]) send_byte(a[i]);
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            checks++;
            if (u_if.im_we_o !== 1'b0 || wr_addr.size() != 0 || u_if.byte_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL gap_cycle_%0d: got we %b writes %0d ready %b, required 0 0 1",
                         k, u_if.im_we_o, wr_addr.size(), u_if.byte_ready_o);
            end
        end
        foreach (b[i]) send_byte(b[i]);
        idle_cycle();
        checks++;
        if (done !== 1'b1 || words !== 6'd2) begin
            errors++;
            $display("FAIL gap_status: got done %b words %0d, required 1 2", done, words);
        end
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL gap_write_count: got %0d, required 2", wr_addr.size());
        end else if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h20010005 ||
                     wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h20020003) begin
            errors++;
            $display("FAIL gap_writes: got %h/%h %h/%h, required 00000000/20010005 00000004/20020003",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
        pulse_start();
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] a [6] = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h20};
        logic [7:0] b [6] = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        clear_log();
        foreach (a[i]) send_byte(a[i]);
        @(negedge clk);
        u_if.byte_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cpu_rst !== 1'b0 || words !== 6'd0 || u_if.im_we_o !== 1'b0 || u_if.byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async: got cpu_rst %b words %0d we %b ready %b, required 0 0 0 1",
                     cpu_rst, words, u_if.im_we_o, u_if.byte_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        foreach (b[i]) send_byte(b[i]);
        idle_cycle();
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b1 || words !== 6'd1) begin
            errors++;
            $display("FAIL midrst_status: got done %b cpu_rst %b words %0d, required 1 1 1", done, cpu_rst, words);
        end
        checks++;
        if (wr_addr.size() != 1) begin
            errors++;
            $display("FAIL midrst_write_count: got %0d, required 1", wr_addr.size());
        end else if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL midrst_write: got %h/%h, required 00000000/deadbeef", wr_addr[0], wr_data[0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_bad_header();
        test_gap();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle CPU: loads a program into instruction memory over a byte stream before the CPU runs.
- Holds the CPU in reset while loading. Releases the CPU only after a verified load.
- Input is a byte stream with a valid/ready handshake. The block assembles bytes into big-endian 32-bit words, writes them into instruction memory from address 0, and checks an XOR checksum.

Parameters:
- MAX_WORDS, 32, instruction-memory capacity in words; the largest legal program length.
- CNT_W, 6, width of the word counter; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- byte_i  in  8  stream data byte.
- byte_valid_i  in  1  byte_i is valid this cycle.
- byte_ready_o  out  1  block can accept a byte this cycle.
- start_i  in  1  soft restart pulse; honoured only in DONE or ERR.
- im_we_o  out  1  instruction-memory write strobe, one-cycle pulse per word.
- im_addr_o  out  32  instruction-memory byte address (word index × 4).
- im_data_o  out  32  word to write.
- cpu_rst_o  out  1  active-low reset driven to the CPU; 0 = CPU held in reset.
- done_o  out  1  load completed with a good checksum.
- err_o  out  1  load aborted: bad length or bad checksum.
- words_loaded_o  out  CNT_W  count of words written in the current load.

Behaviour:
- rst_i low, asynchronous: state=IDLE, byte_ready_o=1, im_we_o=0, im_addr_o=0, im_data_o=0, cpu_rst_o=0, done_o=0, err_o=0, words_loaded_o=0. Byte index, length and checksum registers are also cleared.
- A byte transfer occurs on any edge where byte_valid_i && byte_ready_o. With byte_valid_i low, nothing changes and partial-word state is held.
- byte_ready_o is combinational from state: 1 in IDLE, LOAD and CHECK; 0 in DONE and ERR.

States and transitions:
- IDLE: the first accepted byte is the length header N.
  - N==0 or N>MAX_WORDS: go to ERR; err_o=1 from the next cycle.
  - Otherwise: latch N, clear checksum, byte index and words_loaded_o; go to LOAD.
- LOAD: shift each byte into the word assembler, MSB first. Byte 0 lands in bits [31:24] and byte 3 in [7:0]. Each byte is XORed into the 8-bit checksum.
  - On the edge that accepts byte 3 of a word, register im_data_o = assembled word and im_addr_o = words_loaded_o×4, pulse im_we_o for exactly one cycle, and increment words_loaded_o.
  - The write is visible one cycle after the 4th byte is accepted.
  - When the incremented count equals N, go to CHECK.
- CHECK: the next accepted byte is compared with the checksum (XOR of all 4N data bytes; the header is excluded).
  - Equal: go to DONE.
  - Not equal: go to ERR.
  - The last word's im_we_o pulse occurs in the first CHECK cycle. No extra write is issued.
- DONE: done_o=1 and cpu_rst_o=1, both registered, asserted the cycle after the checksum byte is accepted.
- ERR: err_o=1, cpu_rst_o=0, done_o=0.
- start_i in DONE or ERR: go to IDLE. On that edge, clear done_o, err_o, cpu_rst_o and words_loaded_o.
- start_i in any other state is ignored.
- im_we_o is 0 in every cycle other than the single write pulse. im_addr_o and im_data_o hold their last value between writes.
- Reset asserted mid-load aborts immediately. Partially written memory is left as is, the CPU stays in reset, and a new header is expected after release.
- Arithmetic: im_addr_o = {zero-extended words_loaded_o, 2'b00}. The word counter never wraps, because N ≤ MAX_WORDS < 2^CNT_W.

Test Plan:
- Reset check: hold rst_i=0, then release -> all outputs at their reset values and byte_ready_o=1.
- Good load, bytes 02,20,01,00,05,20,02,00,03,05 back-to-back:
  - im_we_o pulses with addr 0x0/data 0x20010005, then addr 0x4/data 0x20020003.
  - words_loaded_o=2.
  - done_o=1 and cpu_rst_o=1 one cycle after byte 05 is accepted; byte_ready_o=0.
- Same stream with checksum 06 -> err_o=1, cpu_rst_o stays 0, done_o=0. Then a start_i pulse -> IDLE with err_o=0.
- Header 00, then separately header 33 (MAX_WORDS=32) -> ERR on the next cycle, with no im_we_o pulses.
- Good load with byte_valid_i dropped for 3 cycles between bytes 2 and 3 of word 0 -> same writes and values as back-to-back; im_we_o stays 0 during the gap.
- rst_i pulsed low after 5 data bytes, then a full 1-word load 01,DE,AD,BE,EF,22 -> a single write of addr 0x0/data 0xDEADBEEF, then done_o=1.
